// File: rtl/dfx_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfx_axil_pkg
// Description : Shared constants, register map offsets, FSM state encodings
//               and byte-lane helpers for the DFX AXI-Lite control block.
// Revision    : 1.0 - initial release
// ============================================================================
package dfx_axil_pkg;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;

    localparam logic [31:0] OFF_ID         = 32'h0000_0000;
    localparam logic [31:0] OFF_SCRATCH    = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL_BASE  = 32'h0000_0100;
    localparam logic [31:0] OFF_STAT_BASE  = 32'h0000_0200;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_t;

    // Clear the byte-offset bits so every access decodes as a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dfx_axil_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : dfx_axil_ctrl_regs
// Description : AXI-Lite slave exposing an ID word, a scratch register,
//               NUM_CTRL control registers (with write strobes) and NUM_STAT
//               status inputs. Independent read/write paths, one outstanding
//               transaction per direction.
// Revision    : 1.0 - initial release
// ============================================================================
module dfx_axil_ctrl_regs
    import dfx_axil_pkg::*;
#(
    parameter int          NUM_CTRL = 4,
    parameter int          NUM_STAT = 4,
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] ID_VALUE = 32'hDF10_0001,
    parameter logic [31:0] CTRL_RST = 32'h0
) (
    input  logic                     AxiBusClock,
    input  logic                     xAxiBusReset,
    input  logic [ADDR_W-1:0]        xPcieToDfx_AXI_awaddr,
    input  logic [2:0]               xPcieToDfx_AXI_awprot,
    input  logic                     xPcieToDfx_AXI_awvalid,
    output logic                     xPcieToDfx_AXI_awready,
    input  logic [31:0]              xPcieToDfx_AXI_wdata,
    input  logic [3:0]               xPcieToDfx_AXI_wstrb,
    input  logic                     xPcieToDfx_AXI_wvalid,
    output logic                     xPcieToDfx_AXI_wready,
    output logic [1:0]               xPcieToDfx_AXI_bresp,
    output logic                     xPcieToDfx_AXI_bvalid,
    input  logic                     xPcieToDfx_AXI_bready,
    input  logic [ADDR_W-1:0]        xPcieToDfx_AXI_araddr,
    input  logic [2:0]               xPcieToDfx_AXI_arprot,
    input  logic                     xPcieToDfx_AXI_arvalid,
    output logic                     xPcieToDfx_AXI_arready,
    output logic [31:0]              xPcieToDfx_AXI_rdata,
    output logic [1:0]               xPcieToDfx_AXI_rresp,
    output logic                     xPcieToDfx_AXI_rvalid,
    input  logic                     xPcieToDfx_AXI_rready,
    output logic [NUM_CTRL*32-1:0]   xCtrl,
    output logic [NUM_CTRL-1:0]      xCtrlWrPulse,
    input  logic [NUM_STAT*32-1:0]   xStat
);

    wr_state_t               r_wstate;
    rd_state_t               r_rstate;
    logic                    r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]              r_bresp, r_rresp;
    logic [31:0]             r_rdata;
    logic [31:0]             r_aw_addr, r_w_data;
    logic [3:0]              r_w_strb;
    logic [31:0]             r_scratch;
    logic [NUM_CTRL*32-1:0]  r_ctrl;
    logic [NUM_CTRL-1:0]     r_pulse;

    logic                    w_aw_hs, w_w_hs, w_ar_hs;
    logic                    w_commit;
    logic [31:0]             w_c_addr, w_c_data, w_c_word;
    logic [3:0]              w_c_strb;
    logic                    w_hit_scratch, w_wr_ok;
    logic [NUM_CTRL-1:0]     w_hit_ctrl;
    logic [1:0]              w_bresp;
    logic [31:0]             w_r_word, w_rd_data;
    logic                    w_rd_err;
    logic                    unused_prot;

    assign w_aw_hs = xPcieToDfx_AXI_awvalid & r_awready;
    assign w_w_hs  = xPcieToDfx_AXI_wvalid  & r_wready;
    assign w_ar_hs = xPcieToDfx_AXI_arvalid & r_arready;

    // Protection attributes carry no meaning for this register block.
    assign unused_prot = ^{xPcieToDfx_AXI_awprot, xPcieToDfx_AXI_arprot};

    // Select the write that completes this cycle (last of AW/W) and decode its target.
    always_comb begin
        w_commit = 1'b0;
        w_c_addr = r_aw_addr;
        w_c_data = r_w_data;
        w_c_strb = r_w_strb;
        case (r_wstate)
            W_IDLE: begin
                w_commit = w_aw_hs & w_w_hs;
                w_c_addr = 32'(xPcieToDfx_AXI_awaddr);
                w_c_data = xPcieToDfx_AXI_wdata;
                w_c_strb = xPcieToDfx_AXI_wstrb;
            end
            W_HAVE_AW: begin
                w_commit = w_w_hs;
                w_c_data = xPcieToDfx_AXI_wdata;
                w_c_strb = xPcieToDfx_AXI_wstrb;
            end
            W_HAVE_W: begin
                w_commit = w_aw_hs;
                w_c_addr = 32'(xPcieToDfx_AXI_awaddr);
            end
            default: w_commit = 1'b0;
        endcase
        w_c_word      = word_align(w_c_addr);
        w_hit_scratch = (w_c_word == OFF_SCRATCH);
        w_hit_ctrl    = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_c_word == OFF_CTRL_BASE + 32'(4 * i)) w_hit_ctrl[i] = 1'b1;
        end
        w_wr_ok = w_hit_scratch | (|w_hit_ctrl);
        w_bresp = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Read decode of the address presented on the AR channel.
    always_comb begin
        w_r_word  = word_align(32'(xPcieToDfx_AXI_araddr));
        w_rd_data = '0;
        w_rd_err  = 1'b1;
        if (w_r_word == OFF_ID) begin
            w_rd_data = ID_VALUE;
            w_rd_err  = 1'b0;
        end
        if (w_r_word == OFF_SCRATCH) begin
            w_rd_data = r_scratch;
            w_rd_err  = 1'b0;
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (w_r_word == OFF_CTRL_BASE + 32'(4 * i)) begin
                w_rd_data = r_ctrl[32*i +: 32];
                w_rd_err  = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STAT; i++) begin
            if (w_r_word == OFF_STAT_BASE + 32'(4 * i)) begin
                w_rd_data = xStat[32*i +: 32];
                w_rd_err  = 1'b0;
            end
        end
    end

    // Write channel FSM: collects AW and W in either order, then holds the response.
    always_ff @(posedge AxiBusClock or posedge xAxiBusReset) begin
        if (xAxiBusReset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_addr <= '0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_bresp;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wstate  <= W_HAVE_AW;
                        r_aw_addr <= 32'(xPcieToDfx_AXI_awaddr);
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                    end else if (w_w_hs) begin
                        r_wstate  <= W_HAVE_W;
                        r_w_data  <= xPcieToDfx_AXI_wdata;
                        r_w_strb  <= xPcieToDfx_AXI_wstrb;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b0;
                    end else begin
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (xPcieToDfx_AXI_bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: r_wstate <= r_wstate;
            endcase
        end
    end

    // Register file update and per-register write strobe, aligned with bvalid.
    always_ff @(posedge AxiBusClock or posedge xAxiBusReset) begin
        if (xAxiBusReset) begin
            r_ctrl    <= {NUM_CTRL{CTRL_RST}};
            r_scratch <= '0;
            r_pulse   <= '0;
        end else begin
            r_pulse <= '0;
            if (w_commit && w_hit_scratch) begin
                r_scratch <= strb_merge(r_scratch, w_c_data, w_c_strb);
            end
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (w_commit && w_hit_ctrl[i]) begin
                    r_ctrl[32*i +: 32] <= strb_merge(r_ctrl[32*i +: 32], w_c_data, w_c_strb);
                    r_pulse[i]         <= 1'b1;
                end
            end
        end
    end

    // Read channel FSM: capture data on the AR handshake and hold it until rready.
    always_ff @(posedge AxiBusClock or posedge xAxiBusReset) begin
        if (xAxiBusReset) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rstate  <= R_RESP;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (xPcieToDfx_AXI_rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign xPcieToDfx_AXI_awready = r_awready;
    assign xPcieToDfx_AXI_wready  = r_wready;
    assign xPcieToDfx_AXI_bvalid  = r_bvalid;
    assign xPcieToDfx_AXI_bresp   = r_bresp;
    assign xPcieToDfx_AXI_arready = r_arready;
    assign xPcieToDfx_AXI_rvalid  = r_rvalid;
    assign xPcieToDfx_AXI_rresp   = r_rresp;
    assign xPcieToDfx_AXI_rdata   = r_rdata;
    assign xCtrl                  = r_ctrl;
    assign xCtrlWrPulse           = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_dfx_axil_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_dfx_axil_ctrl_regs
// Description : Self-checking bench for dfx_axil_ctrl_regs. A transaction
//               level model of the register map and handshake rules runs
//               alongside the DUT and is compared every cycle; directed
//               sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dfx_axil_ctrl_regs;

    localparam int NUM_CTRL = 4;
    localparam int NUM_STAT = 4;
    localparam int ADDR_W   = 12;
    localparam logic [31:0] ID_VALUE = 32'hDF10_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [NUM_CTRL*32-1:0] ctrl;
    logic [NUM_CTRL-1:0]    pulse;
    logic [NUM_STAT*32-1:0] stat = '0;

    int vectors = 0;
    int miscompares = 0;
    bit rand_rdy = 0;

    dfx_axil_ctrl_regs #(
        .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT), .ADDR_W(ADDR_W),
        .ID_VALUE(ID_VALUE), .CTRL_RST(32'h0)
    ) dut (
        .AxiBusClock(clk), .xAxiBusReset(rst),
        .xPcieToDfx_AXI_awaddr(awaddr), .xPcieToDfx_AXI_awprot(awprot),
        .xPcieToDfx_AXI_awvalid(awvalid), .xPcieToDfx_AXI_awready(awready),
        .xPcieToDfx_AXI_wdata(wdata), .xPcieToDfx_AXI_wstrb(wstrb),
        .xPcieToDfx_AXI_wvalid(wvalid), .xPcieToDfx_AXI_wready(wready),
        .xPcieToDfx_AXI_bresp(bresp), .xPcieToDfx_AXI_bvalid(bvalid),
        .xPcieToDfx_AXI_bready(bready),
        .xPcieToDfx_AXI_araddr(araddr), .xPcieToDfx_AXI_arprot(arprot),
        .xPcieToDfx_AXI_arvalid(arvalid), .xPcieToDfx_AXI_arready(arready),
        .xPcieToDfx_AXI_rdata(rdata), .xPcieToDfx_AXI_rresp(rresp),
        .xPcieToDfx_AXI_rvalid(rvalid), .xPcieToDfx_AXI_rready(rready),
        .xCtrl(ctrl), .xCtrlWrPulse(pulse), .xStat(stat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ctrl [NUM_CTRL];
    logic [31:0] m_scratch;
    bit          m_up, aw_have, w_have, b_pend, r_pend;
    logic [31:0] aw_a, w_d, r_data_e;
    logic [3:0]  w_s;
    logic [1:0]  b_resp_e, r_resp_e;
    logic [NUM_CTRL-1:0] pulse_e;

    function automatic int ctrl_index(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w >= 32'h100 && w < 32'h100 + 4 * NUM_CTRL) return int'((w - 32'h100) / 4);
        return -1;
    endfunction

    function automatic int stat_index(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if (w >= 32'h200 && w < 32'h200 + 4 * NUM_STAT) return int'((w - 32'h200) / 4);
        return -1;
    endfunction

    // Model advances on each rising edge from the handshakes seen on the bus.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CTRL; i++) m_ctrl[i] = 32'h0;
            m_scratch = 0; m_up = 0; aw_have = 0; w_have = 0; b_pend = 0; r_pend = 0;
            pulse_e = '0; b_resp_e = 0; r_resp_e = 0; r_data_e = 0;
        end else begin
            pulse_e = '0;
            if (r_pend && rready) r_pend = 0;
            if (arvalid && arready) begin
                logic [31:0] a;
                a = 32'(araddr) & ~32'h3;
                r_pend = 1; r_data_e = 0; r_resp_e = 2'b10;
                if (a == 0) begin r_data_e = ID_VALUE; r_resp_e = 0; end
                else if (a == 4) begin r_data_e = m_scratch; r_resp_e = 0; end
                else if (ctrl_index(a) >= 0) begin r_data_e = m_ctrl[ctrl_index(a)]; r_resp_e = 0; end
                else if (stat_index(a) >= 0) begin r_data_e = stat[32*stat_index(a) +: 32]; r_resp_e = 0; end
            end
            if (b_pend && bready) b_pend = 0;
            if (awvalid && awready) begin aw_have = 1; aw_a = 32'(awaddr); end
            if (wvalid && wready) begin w_have = 1; w_d = wdata; w_s = wstrb; end
            if (aw_have && w_have) begin
                logic [31:0] a, v;
                int k;
                a = aw_a & ~32'h3;
                k = ctrl_index(a);
                b_resp_e = 2'b10;
                if (a == 4) begin
                    v = m_scratch;
                    for (int b = 0; b < 4; b++) if (w_s[b]) v[8*b +: 8] = w_d[8*b +: 8];
                    m_scratch = v; b_resp_e = 0;
                end else if (k >= 0) begin
                    v = m_ctrl[k];
                    for (int b = 0; b < 4; b++) if (w_s[b]) v[8*b +: 8] = w_d[8*b +: 8];
                    m_ctrl[k] = v; pulse_e[k] = 1'b1; b_resp_e = 0;
                end
                b_pend = 1; aw_have = 0; w_have = 0;
            end
            m_up = 1;
        end
    end

    // Compare DUT outputs against the model shortly after every rising edge.
    always @(posedge clk) begin
        #3;
        if (rst) begin
            chk("rst_awready", awready, 0); chk("rst_wready", wready, 0);
            chk("rst_arready", arready, 0); chk("rst_bvalid", bvalid, 0);
            chk("rst_rvalid", rvalid, 0);   chk("rst_bresp", bresp, 0);
            chk("rst_rresp", rresp, 0);     chk("rst_rdata", rdata, 0);
            chk("rst_pulse", pulse, 0);     chk("rst_ctrl", ctrl, 0);
        end else begin
            logic [NUM_CTRL*32-1:0] ce;
            for (int i = 0; i < NUM_CTRL; i++) ce[32*i +: 32] = m_ctrl[i];
            chk("ctrl", ctrl, ce);
            chk("pulse", pulse, pulse_e);
            chk("awready", awready, m_up && !aw_have && !b_pend);
            chk("wready", wready, m_up && !w_have && !b_pend);
            chk("arready", arready, m_up && !r_pend);
            chk("bvalid", bvalid, b_pend);
            chk("rvalid", rvalid, r_pend);
            if (b_pend) chk("bresp", bresp, b_resp_e);
            if (r_pend) begin
                chk("rresp", rresp, r_resp_e);
                chk("rdata", rdata, r_data_e);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (rand_rdy) begin
            bready = ($urandom % 3) != 0;
            rready = ($urandom % 3) != 0;
        end
        for (int i = 0; i < NUM_STAT; i++) stat[32*i +: 32] = $urandom;
    endtask

    task automatic xfer(input bit en_aw, input bit en_w, input bit en_ar,
                        input logic [31:0] wa, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] ra);
        bit a_go, w_go, r_go;
        if (en_aw) begin awaddr = wa[ADDR_W-1:0]; awprot = 3'($urandom); awvalid = 1; end
        if (en_w)  begin wdata = wd; wstrb = ws; wvalid = 1; end
        if (en_ar) begin araddr = ra[ADDR_W-1:0]; arprot = 3'($urandom); arvalid = 1; end
        for (int n = 0; n < 200; n++) begin
            a_go = awvalid && awready;
            w_go = wvalid && wready;
            r_go = arvalid && arready;
            tick();
            if (a_go) awvalid = 0;
            if (w_go) wvalid = 0;
            if (r_go) arvalid = 0;
            if (!awvalid && !wvalid && !arvalid) return;
        end
        vectors++; miscompares++;
        $display("FAIL xfer_timeout: got aw=%0b w=%0b ar=%0b still pending expected accepted", awvalid, wvalid, arvalid);
        awvalid = 0; wvalid = 0; arvalid = 0;
    endtask

    task automatic wait_b();
        bready = 1;
        for (int n = 0; n < 50; n++) begin
            if (bvalid) begin tick(); bready = 0; return; end
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL bvalid_timeout: got bvalid=0 expected 1");
        bready = 0;
    endtask

    task automatic wait_r();
        rready = 1;
        for (int n = 0; n < 50; n++) begin
            if (rvalid) begin tick(); rready = 0; return; end
            tick();
        end
        vectors++; miscompares++;
        $display("FAIL rvalid_timeout: got rvalid=0 expected 1");
        rready = 0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom % 8)
            0: a = 32'h000;
            1: a = 32'h004;
            2, 3: a = 32'h100 + 4 * ($urandom % 6);
            4, 5: a = 32'h200 + 4 * ($urandom % 6);
            6: a = 32'h300;
            default: a = $urandom % 4096;
        endcase
        return a | ($urandom % 4);
    endfunction

    initial begin
        repeat (3) tick();
        rst = 0;
        tick();
        chk("rel_awready", awready, 1);
        chk("rel_wready", wready, 1);
        chk("rel_arready", arready, 1);

        // ID read, one-cycle latency
        xfer(0, 0, 1, 0, 0, 0, 32'h000);
        chk("id_rvalid", rvalid, 1);
        chk("id_rdata", rdata, 32'hDF10_0001);
        chk("id_rresp", rresp, 2'b00);
        wait_r();

        // AW ahead of W, partial strobe
        xfer(1, 0, 0, 32'h104, 0, 0, 0);
        tick(); tick();
        xfer(0, 1, 0, 0, 32'hA5A5_1234, 4'b0011, 0);
        chk("c1_value", ctrl[63:32], 32'h0000_1234);
        chk("c1_pulse", pulse, 4'b0010);
        chk("c1_bresp", bresp, 2'b00);
        tick();
        chk("c1_pulse_gone", pulse, 4'b0000);
        wait_b();

        // RO target write, unmapped read
        xfer(1, 1, 0, 32'h200, 32'hFFFF_FFFF, 4'hF, 0);
        chk("ro_bresp", bresp, 2'b10);
        chk("ro_ctrl", ctrl, 128'h0000_0000_0000_0000_0000_1234_0000_0000);
        chk("ro_pulse", pulse, 4'b0000);
        wait_b();
        xfer(0, 0, 1, 0, 0, 0, 32'h300);
        chk("um_rresp", rresp, 2'b10);
        chk("um_rdata", rdata, 32'h0);
        wait_r();

        // Write response backpressure
        xfer(1, 1, 0, 32'h004, 32'h1234_5678, 4'hF, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_bvalid", bvalid, 1);
            chk("bp_awready", awready, 0);
            chk("bp_wready", wready, 0);
        end
        wait_b();
        xfer(1, 1, 0, 32'h108, 32'hCAFE_0001, 4'hF, 0);
        chk("bp_next_bresp", bresp, 2'b00);
        wait_b();
        xfer(0, 0, 1, 0, 0, 0, 32'h004);
        chk("scratch_rdata", rdata, 32'h1234_5678);
        wait_r();

        // Simultaneous read and write of control 0
        xfer(1, 1, 1, 32'h100, 32'h1, 4'hF, 32'h100);
        chk("rw_old_rdata", rdata, 32'h0);
        wait_r(); wait_b();
        xfer(0, 0, 1, 0, 0, 0, 32'h100);
        chk("rw_new_rdata", rdata, 32'h1);
        wait_r();

        // Reset while only the address has been accepted
        xfer(1, 0, 0, 32'h10C, 0, 0, 0);
        rst = 1;
        tick(); tick();
        chk("arst_bvalid", bvalid, 0);
        chk("arst_ctrl", ctrl, 128'h0);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_arst_bvalid", bvalid, 0);
        end

        // Randomized traffic
        rand_rdy = 1;
        for (int it = 0; it < 400; it++) begin
            logic [31:0] a, d, ra;
            logic [3:0]  s;
            a = pick_addr(); d = $urandom; s = 4'($urandom); ra = pick_addr();
            case ($urandom % 5)
                0: xfer(1, 1, 0, a, d, s, 0);
                1: begin xfer(1, 0, 0, a, 0, 0, 0); repeat ($urandom % 3) tick(); xfer(0, 1, 0, 0, d, s, 0); end
                2: begin xfer(0, 1, 0, 0, d, s, 0); repeat ($urandom % 3) tick(); xfer(1, 0, 0, a, 0, 0, 0); end
                3: xfer(0, 0, 1, 0, 0, 0, ra);
                default: xfer(1, 1, 1, a, d, s, ra);
            endcase
            repeat ($urandom % 3) tick();
        end
        rand_rdy = 0;
        bready = 1; rready = 1;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
